// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word, register index and decode/execute bundle types
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W = 5;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0] regbits_t;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
  typedef struct packed {
    logic dREN;
    logic dWEN;
    logic regWr;
    logic [1:0] regSel;
    aluop_t ALUOp;
    logic ALUSrc;
    logic halt;
    logic uses_rt;
  } ctrl_t;
  typedef struct packed {
    word_t nPC;
    word_t rdat1;
    word_t rdat2;
    word_t imm;
    word_t lui;
    logic [4:0] shamt;
    regbits_t rs;
    regbits_t rt;
    regbits_t regDst;
  } data_t;
endpackage

// File: rtl/lu_hazard_unit.sv
// lu_hazard_unit: flags a decode instruction that reads the destination of a load held in execute
module lu_hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_dren,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             id_valid,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             stall
);
  assign stall = ex_valid && ex_dren && ex_dst != '0 && id_valid &&
                 (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
endmodule

// File: rtl/decode_exec_latch.sv
// decode_exec_latch: decode->execute pipeline register with load-use bubbles, flush and sticky halt
module decode_exec_latch
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int REG_W = cpu_types_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  ctrl_t            in_ctrl,
  input  data_t            in_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output ctrl_t            out_ctrl,
  output data_t            out_data,
  output logic             lu_stall,
  output logic             halt_out,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic xfer;
  if (DATA_W != WORD_W || REG_W != cpu_types_pkg::REG_W) begin : g_width_check
    $error("decode_exec_latch: DATA_W/REG_W must match cpu_types_pkg bundle widths");
  end
  lu_hazard_unit #(.REG_W(REG_W)) u_hazard (
    .ex_valid  (out_valid),
    .ex_dren   (out_ctrl.dREN),
    .ex_dst    (out_data.regDst),
    .id_valid  (in_valid),
    .id_uses_rt(in_ctrl.uses_rt),
    .id_rs     (in_data.rs),
    .id_rt     (in_data.rt),
    .stall     (lu_stall)
  );
  assign in_ready = (!out_valid || ex_ready) && !lu_stall && !flush && !halt_out;
  assign xfer = in_valid && in_ready;
  // latch update priority: flush, then transfer, then load-use bubble, then drain; otherwise hold
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      halt_out   <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
      halt_out  <= in_ctrl.halt;
    end else if (lu_stall && ex_ready) begin
      out_valid     <= 1'b0;
      out_ctrl.dREN  <= 1'b0;
      out_ctrl.dWEN  <= 1'b0;
      out_ctrl.regWr <= 1'b0;
      out_ctrl.halt  <= 1'b0;
      bubble_cnt    <= (&bubble_cnt) ? bubble_cnt : bubble_cnt + 1'b1;
    end else if (ex_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_exec_latch.sv
// tb_decode_exec_latch: randomized and directed scoreboard bench for decode_exec_latch
module tb_decode_exec_latch;
  import cpu_types_pkg::*;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  typedef logic [$bits(ctrl_t)+$bits(data_t)-1:0] pay_t;
  logic CLK, nRST, in_valid, in_ready, flush, ex_ready, out_valid, lu_stall, halt_out;
  ctrl_t in_ctrl, out_ctrl;
  data_t in_data, out_data;
  logic [CW-1:0] bubble_cnt;
  int vectors = 0, errs = 0;
  pay_t sb[$];
  logic m_valid, m_dren, m_halt;
  logic [4:0] m_dst;
  int m_cnt, last_ev;

  decode_exec_latch #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .ex_ready(ex_ready),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data),
    .lu_stall(lu_stall), .halt_out(halt_out), .bubble_cnt(bubble_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every instruction execute consumes must be the oldest accepted one
  always @(negedge CLK) begin
    if (nRST && out_valid && ex_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL payload: got %0h expected nothing queued at %0t", {out_ctrl, out_data}, $time);
      end else begin
        if ({out_ctrl, out_data} !== sb[0]) begin
          errs++;
          $display("FAIL payload: got %0h expected %0h at %0t", {out_ctrl, out_data}, sb[0], $time);
        end
        void'(sb.pop_front());
      end
    end
  end

  function automatic ctrl_t rnd_ctrl();
    ctrl_t c;
    c.dREN = 1'($urandom_range(0, 1));
    c.dWEN = 1'($urandom_range(0, 1));
    c.regWr = 1'($urandom_range(0, 1));
    c.regSel = 2'($urandom_range(0, 3));
    c.ALUOp = aluop_t'(4'($urandom_range(0, 9)));
    c.ALUSrc = 1'($urandom_range(0, 1));
    c.halt = 1'b0;
    c.uses_rt = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic data_t rnd_data();
    data_t d;
    d.nPC = $urandom;
    d.rdat1 = $urandom;
    d.rdat2 = $urandom;
    d.imm = $urandom;
    d.lui = $urandom;
    d.shamt = 5'($urandom_range(0, 31));
    d.rs = 5'($urandom_range(0, 3));
    d.rt = 5'($urandom_range(0, 3));
    d.regDst = 5'($urandom_range(0, 3));
    return d;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0; in_ctrl = '0; in_data = '0;
    nRST = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data_any", |out_data, 0);
    chk("rst_halt_out", halt_out, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    nRST = 1'b1;
    m_valid = 0; m_dren = 0; m_halt = 0; m_dst = 0; m_cnt = 0;
    sb.delete();
    @(posedge CLK); #1;
  endtask

  // one clock: drive inputs, check handshake/hazard, advance the reference model, check state
  task automatic step(input logic iv, input ctrl_t c, input data_t d, input logic fl, input logic er);
    logic hz, rdy;
    in_valid = iv; in_ctrl = c; in_data = d; flush = fl; ex_ready = er;
    hz = m_valid && m_dren && m_dst != 0 && iv && (m_dst == d.rs || (c.uses_rt && m_dst == d.rt));
    rdy = (!m_valid || er) && !hz && !fl && !m_halt;
    #1;
    chk("in_ready", in_ready, rdy);
    chk("lu_stall", lu_stall, hz);
    if (iv && rdy) sb.push_back({c, d});
    else if (fl && m_valid && !er && sb.size() > 0) void'(sb.pop_front());
    if (fl) begin
      m_valid = 0; last_ev = 2;
    end else if (iv && rdy) begin
      m_valid = 1; m_dren = c.dREN; m_dst = d.regDst; m_halt = m_halt | c.halt; last_ev = 0;
    end else if (hz && er) begin
      m_valid = 0; m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1; last_ev = 1;
    end else begin
      if (er) m_valid = 0;
      last_ev = 0;
    end
    @(posedge CLK); #1;
    chk("out_valid", out_valid, m_valid);
    chk("halt_out", halt_out, m_halt);
    chk("bubble_cnt", bubble_cnt, m_cnt);
    if (last_ev == 2) chk("flush_ctrl", out_ctrl, 0);
    if (last_ev == 1) chk("bubble_ctrl", {out_ctrl.dREN, out_ctrl.dWEN, out_ctrl.regWr, out_ctrl.halt}, 0);
  endtask

  initial begin
    ctrl_t add_c, lw_c, halt_c;
    data_t da, db, dl;
    nRST = 1'b0;
    do_reset();
    add_c = '0; add_c.regWr = 1; add_c.ALUOp = ALU_ADD; add_c.uses_rt = 1;
    lw_c = '0; lw_c.dREN = 1; lw_c.regWr = 1; lw_c.ALUOp = ALU_ADD; lw_c.ALUSrc = 1;
    halt_c = '0; halt_c.halt = 1;
    da = rnd_data(); da.regDst = 3;
    step(1, add_c, da, 0, 1);
    chk("basic_regdst", out_data.regDst, 3);
    dl = rnd_data(); dl.regDst = 8;
    step(1, lw_c, dl, 0, 1);
    db = rnd_data(); db.rs = 8; db.rt = 1;
    step(1, add_c, db, 0, 1);
    chk("lu_bubble_cnt", bubble_cnt, 1);
    chk("lu_bubble_regwr", out_ctrl.regWr, 0);
    step(1, add_c, db, 0, 1);
    chk("lu_after_rs", out_data.rs, 8);
    dl.regDst = 0;
    step(1, lw_c, dl, 0, 1);
    db.rs = 0; db.rt = 0;
    step(1, add_c, db, 0, 1);
    chk("zero_reg_cnt", bubble_cnt, 1);
    chk("zero_reg_valid", out_valid, 1);
    da = rnd_data(); db = rnd_data();
    step(1, add_c, da, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, add_c, db, 0, 0);
      chk("bp_hold", out_data == da, 1);
    end
    step(1, add_c, db, 0, 1);
    chk("bp_transfer", out_data == db, 1);
    dl = rnd_data(); dl.regDst = 2;
    db = rnd_data(); db.rs = 2;
    for (int i = 0; i < 9; i++) begin
      step(1, lw_c, dl, 0, 1);
      step(1, add_c, db, 0, 1);
    end
    chk("sat_cnt", bubble_cnt, CMAX);
    step(1, lw_c, dl, 0, 1);
    in_valid = 1; in_ctrl = add_c; in_data = db; ex_ready = 0; flush = 0;
    #1;
    chk("mid_stall", lu_stall, 1);
    do_reset();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_ctrl(), rnd_data(),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
    do_reset();
    step(1, halt_c, rnd_data(), 1, 1);
    chk("flush_halt", halt_out, 0);
    chk("flush_halt_cnt", bubble_cnt, 0);
    step(1, halt_c, rnd_data(), 0, 1);
    chk("halt_rise", halt_out, 1);
    for (int i = 0; i < 4; i++) step(1, rnd_ctrl(), rnd_data(), 0, 1);
    chk("halt_sticky", halt_out, 1);
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
